// File: rtl/up_down_counter_pkg.sv
// ---------------------------------------------------------------------------
// up_down_counter_pkg
//   Shared types for the up/down counter.
//   count_op_t names the action taken on an edge, and select_op resolves the
//   rst > load > count priority into one of those actions.
// ---------------------------------------------------------------------------
package up_down_counter_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_LOAD  = 2'd1,
        OP_INC   = 2'd2,
        OP_DEC   = 2'd3
    } count_op_t;

    function automatic count_op_t select_op(input logic rst,
                                            input logic load,
                                            input logic up_down);
        count_op_t op;
        if (rst)
            op = OP_RESET;
        else if (load)
            op = OP_LOAD;
        else if (up_down)
            op = OP_INC;
        else
            op = OP_DEC;
        return op;
    endfunction

endpackage

// File: rtl/up_down_counter.sv
// ---------------------------------------------------------------------------
// up_down_counter
//   Synchronous binary up/down counter with parallel load. It wraps modulo
//   2^WIDTH and steps on every edge where it is neither reset nor loading.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset (highest priority)
//   up_down    1 = increment, 0 = decrement
//   load       synchronous parallel load enable (beats counting)
//   count_in   preset value captured when load = 1
//   count_out  current counter value, driven straight from the register
// ---------------------------------------------------------------------------
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH-1:0] count_out
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    count_op_t        op;
    logic [WIDTH-1:0] next_count;

    // One priority mux feeding the register. The add and subtract are kept
    // at WIDTH bits, so wrap-around falls out of the truncation.
    always_comb begin
        op         = select_op(rst, load, up_down);
        next_count = count_out;
        case (op)
            OP_RESET: next_count = '0;
            OP_LOAD:  next_count = count_in;
            OP_INC:   next_count = count_out + ONE;
            OP_DEC:   next_count = count_out - ONE;
            default:  next_count = count_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_out <= '0;
        else
            count_out <= next_count;
    end

endmodule

// File: tb/tb_up_down_counter.sv
// ---------------------------------------------------------------------------
// tb_up_down_counter
//   Bench for up_down_counter at WIDTH = 8 and WIDTH = 4. Each directed
//   vector is driven on a falling edge and its expected value is queued;
//   a monitor pops and compares just after every rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_up_down_counter;

    logic       clk;
    logic       rst8, ud8, load8;
    logic [7:0] cin8, count8;
    logic       rst4, ud4, load4;
    logic [3:0] cin4, count4;

    typedef struct {
        logic [7:0] value;
        string      name;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    int checks   = 0;
    int failures = 0;

    up_down_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .up_down(ud8), .load(load8),
        .count_in(cin8), .count_out(count8)
    );

    up_down_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .up_down(ud4), .load(load4),
        .count_in(cin4), .count_out(count4)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic step8(input logic r, input logic l, input logic ud,
                         input logic [7:0] cin, input logic [7:0] exp_v,
                         input string name);
        exp_t e;
        @(negedge clk);
        rst8 = r; load8 = l; ud8 = ud; cin8 = cin;
        e.value = exp_v;
        e.name  = name;
        q8.push_back(e);
    endtask

    task automatic step4(input logic r, input logic l, input logic ud,
                         input logic [3:0] cin, input logic [3:0] exp_v,
                         input string name);
        exp_t e;
        @(negedge clk);
        rst4 = r; load4 = l; ud4 = ud; cin4 = cin;
        e.value = {4'h0, exp_v};
        e.name  = name;
        q4.push_back(e);
    endtask

    // Monitor: each queued entry belongs to the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q8.size() > 0) begin
                e = q8.pop_front();
                checks++;
                if (count8 !== e.value) begin
                    failures++;
                    $display("FAIL w8 %s: got 0x%02h expected 0x%02h", e.name, count8, e.value);
                end
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                checks++;
                if (count4 !== e.value[3:0]) begin
                    failures++;
                    $display("FAIL w4 %s: got 0x%01h expected 0x%01h", e.name, count4, e.value[3:0]);
                end
            end
        end
    end

    initial begin
        rst8 = 1'b1; load8 = 1'b0; ud8 = 1'b1; cin8 = 8'h00;
        rst4 = 1'b1; load4 = 1'b0; ud4 = 1'b1; cin4 = 4'h0;

        // Reset, and reset held against a load request
        step8(1, 0, 1, 8'h00, 8'h00, "reset");
        step8(1, 1, 1, 8'hAA, 8'h00, "reset_over_load");

        // Load then count both ways
        step8(0, 1, 1, 8'h92, 8'h92, "load_92");
        step8(0, 0, 1, 8'h00, 8'h93, "up_93");
        step8(0, 0, 0, 8'h00, 8'h92, "down_92");
        step8(0, 0, 0, 8'h00, 8'h91, "down_91");
        step8(0, 0, 1, 8'h00, 8'h92, "up_92");
        step8(0, 0, 1, 8'h00, 8'h93, "up_93b");
        step8(0, 0, 1, 8'h00, 8'h94, "up_94");

        // Wrap-around in both directions
        step8(0, 1, 0, 8'hFF, 8'hFF, "load_ff");
        step8(0, 0, 1, 8'h00, 8'h00, "wrap_up");
        step8(0, 1, 1, 8'h00, 8'h00, "load_00");
        step8(0, 0, 0, 8'h00, 8'hFF, "wrap_down");

        // Load beats counting, direction ignored while loading
        step8(0, 1, 1, 8'h10, 8'h10, "load_10");
        step8(0, 0, 1, 8'h00, 8'h11, "up_11");
        step8(0, 1, 0, 8'h5A, 8'h5A, "load_over_count");
        step8(0, 0, 0, 8'h00, 8'h59, "down_after_load");

        // Reset mid-count, then resume from zero
        step8(0, 1, 1, 8'h35, 8'h35, "load_35");
        step8(0, 0, 1, 8'h00, 8'h36, "up_36");
        step8(0, 0, 1, 8'h00, 8'h37, "up_37");
        step8(1, 1, 1, 8'h77, 8'h00, "reset_mid_count");
        step8(0, 0, 1, 8'h00, 8'h01, "resume_01");
        step8(0, 0, 1, 8'h00, 8'h02, "resume_02");

        // Narrow instance
        step4(1, 0, 1, 4'h0, 4'h0, "reset");
        step4(0, 1, 1, 4'hF, 4'hF, "load_f");
        step4(0, 0, 1, 4'h0, 4'h0, "wrap_up");
        step4(0, 0, 0, 4'h0, 4'hF, "wrap_down");
        step4(0, 0, 0, 4'h0, 4'hE, "down_e");
        step4(0, 1, 1, 4'h0, 4'h0, "load_0");
        step4(0, 0, 0, 4'h0, 4'hF, "wrap_down_b");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q8.size() != 0 || q4.size() != 0) begin
            failures++;
            $display("FAIL drain: pending %0d/%0d expected 0/0", q8.size(), q4.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
